// File: rtl/vram_wr_seq_pkg.sv
// Shared constants for the VRAM write sequencer: command opcodes, control/status bit
// positions, sequencer state encodings and the layout of a queued command.
package vram_wr_seq_pkg;

    typedef enum logic [1:0] {
        OP_SETADR = 2'b00,
        OP_DATA   = 2'b01,
        OP_FILL   = 2'b10,
        OP_CTRL   = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POP     = 3'd1,
        ST_WRITE   = 3'd2,
        ST_FILL    = 3'd3,
        ST_WAIT_VB = 3'd4
    } state_e;

    localparam int CMD_TOG_BIT       = 15;
    localparam int CMD_OP_MSB        = 14;
    localparam int CMD_OP_LSB        = 13;
    localparam int CMD_PAY_W         = 10;

    localparam int CTRL_FLUSH_BIT    = 0;
    localparam int CTRL_GATE_VAL_BIT = 1;
    localparam int CTRL_GATE_LD_BIT  = 2;

    localparam int STS_ACK_BIT       = 15;
    localparam int STS_OVF_BIT       = 14;
    localparam int STS_BUSY_BIT      = 13;
    localparam int STS_GATE_BIT      = 12;
    localparam int STS_LVL_MSB       = 3;
    localparam int STS_LVL_LSB       = 0;

    typedef struct packed {
        opcode_e               op;
        logic [CMD_PAY_W-1:0]  pay;
    } fifo_entry_t;

endpackage

// File: rtl/vram_wr_seq_cmd_fifo.sv
// Synchronous command FIFO with occupancy level; a simultaneous push and pop always
// both succeed, so a full FIFO can still accept a command on a pop cycle.
module vram_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [LW-1:0]    r_level;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_level == LW'(DEPTH));
    assign o_empty  = (r_level == '0);
    assign o_level  = r_level;
    assign o_rdata  = r_mem[r_rdPtr];
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
            if (w_doPush && !w_doPop)      r_level <= r_level + LW'(1);
            else if (w_doPop && !w_doPush) r_level <= r_level - LW'(1);
        end
    end

    // Storage carries no reset; only the pointers define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_doPush && !i_flush) r_mem[r_wrPtr] <= i_wdata;
    end

endmodule

// File: rtl/vram_wr_seq.sv
// VRAM write sequencer: decodes toggle-handshaked CPU commands, queues address/data/fill
// commands and writes them into VRAM, optionally only during vertical blank.
module vram_wr_seq
    import vram_wr_seq_pkg::*;
#(
    parameter int   C_FIFO_DEPTH  = 8,
    parameter logic C_VB_GATE_DEF = 1'b1
) (
    input  logic        NFSC_CK_i,
    input  logic        XSYS_R_i,
    input  logic [15:0] CMD_i,
    input  logic        XVD_i,
    output logic [9:0]  VRAM_WAs_o,
    output logic [7:0]  VRAM_WDs_o,
    output logic        VRAM_WE_o,
    output logic [15:0] STATUS_o
);
    localparam int LW = $clog2(C_FIFO_DEPTH) + 1;

    logic        r_tog;
    logic        r_push;
    fifo_entry_t r_pushEnt;
    logic        r_ovf;
    logic        r_gate;
    state_e      r_state;
    state_e      r_resume;
    logic [9:0]  r_addr;
    logic [7:0]  r_data;
    logic [9:0]  r_cnt;
    logic        r_we;
    logic [9:0]  r_wa;
    logic [7:0]  r_wd;

    opcode_e     w_cmdOp;
    logic        w_new;
    logic        w_ctrl;
    logic        w_flush;
    logic        w_pop;
    logic        w_drop;
    logic        w_full;
    logic        w_empty;
    logic [LW-1:0] w_level;
    logic [11:0] w_rdata;
    fifo_entry_t w_head;
    logic        w_permit;
    logic        w_busy;
    state_e      w_next;
    logic        w_doWrite;
    logic [4:0]  w_lvl5;
    logic [3:0]  w_lvl4;
    logic        w_unused;

    assign w_cmdOp  = opcode_e'(CMD_i[CMD_OP_MSB:CMD_OP_LSB]);
    assign w_new    = CMD_i[CMD_TOG_BIT] ^ r_tog;
    assign w_ctrl   = w_new && (w_cmdOp == OP_CTRL);
    assign w_flush  = w_ctrl && CMD_i[CTRL_FLUSH_BIT];
    assign w_pop    = (r_state == ST_POP) && !w_empty;
    assign w_drop   = r_push && w_full && !w_pop;
    assign w_head   = w_rdata;
    assign w_permit = !r_gate || !XVD_i;
    assign w_busy   = (r_state != ST_IDLE) || !w_empty;
    assign w_unused = ^CMD_i[12:10];

    vram_cmd_fifo #(
        .DEPTH (C_FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .i_clk   (NFSC_CK_i),
        .i_rst_n (XSYS_R_i),
        .i_flush (w_flush),
        .i_push  (r_push),
        .i_pop   (w_pop),
        .i_wdata (r_pushEnt),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Command capture: CTRL acts at the detection edge, everything else is queued a cycle later.
    always_ff @(posedge NFSC_CK_i or negedge XSYS_R_i) begin
        if (!XSYS_R_i) begin
            r_tog     <= 1'b0;
            r_push    <= 1'b0;
            r_pushEnt <= '0;
            r_ovf     <= 1'b0;
            r_gate    <= C_VB_GATE_DEF;
        end else begin
            r_tog         <= CMD_i[CMD_TOG_BIT];
            r_push        <= w_new && !w_ctrl;
            r_pushEnt.op  <= w_cmdOp;
            r_pushEnt.pay <= CMD_i[CMD_PAY_W-1:0];
            if (w_flush)     r_ovf <= 1'b0;
            else if (w_drop) r_ovf <= 1'b1;
            if (w_ctrl && CMD_i[CTRL_GATE_LD_BIT]) r_gate <= CMD_i[CTRL_GATE_VAL_BIT];
        end
    end

    always_ff @(posedge NFSC_CK_i or negedge XSYS_R_i) begin
        if (!XSYS_R_i)    r_state <= ST_IDLE;
        else if (w_flush) r_state <= ST_IDLE;
        else              r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_doWrite = 1'b0;
        unique case (r_state)
            ST_IDLE: if (!w_empty) w_next = ST_POP;
            ST_POP: begin
                unique case (w_head.op)
                    OP_DATA: w_next = ST_WRITE;
                    OP_FILL: w_next = ST_FILL;
                    default: w_next = ST_IDLE;
                endcase
            end
            ST_WRITE: begin
                if (w_permit) begin
                    w_doWrite = 1'b1;
                    w_next    = ST_IDLE;
                end else begin
                    w_next    = ST_WAIT_VB;
                end
            end
            ST_FILL: begin
                if (w_permit) begin
                    w_doWrite = 1'b1;
                    if (r_cnt == '0) w_next = ST_IDLE;
                end else begin
                    w_next    = ST_WAIT_VB;
                end
            end
            ST_WAIT_VB: if (w_permit) w_next = r_resume;
            default: w_next = ST_IDLE;
        endcase
    end

    // Write datapath; r_cnt counts remaining fill writes beyond the current one.
    always_ff @(posedge NFSC_CK_i or negedge XSYS_R_i) begin
        if (!XSYS_R_i) begin
            r_addr   <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_resume <= ST_WRITE;
            r_we     <= 1'b0;
            r_wa     <= '0;
            r_wd     <= '0;
        end else begin
            r_we <= w_doWrite && !w_flush;
            if (!w_flush) begin
                if (w_doWrite) begin
                    r_wa   <= r_addr;
                    r_wd   <= r_data;
                    r_addr <= r_addr + 10'd1;
                end
                if (w_doWrite && (r_state == ST_FILL)) r_cnt <= r_cnt - 10'd1;
                if (r_state == ST_POP) begin
                    unique case (w_head.op)
                        OP_SETADR: r_addr <= w_head.pay;
                        OP_DATA:   r_data <= w_head.pay[7:0];
                        OP_FILL:   r_cnt  <= w_head.pay;
                        default:   ;
                    endcase
                end
                if ((w_next == ST_WAIT_VB) && (r_state != ST_WAIT_VB)) r_resume <= r_state;
            end
        end
    end

    assign VRAM_WE_o  = r_we;
    assign VRAM_WAs_o = r_wa;
    assign VRAM_WDs_o = r_wd;

    // Level saturates so a 16-deep FIFO still reports sensibly in four bits.
    assign w_lvl5 = 5'(w_level);
    assign w_lvl4 = w_lvl5[4] ? 4'hF : w_lvl5[3:0];

    always_comb begin
        STATUS_o                          = '0;
        STATUS_o[STS_ACK_BIT]             = r_tog;
        STATUS_o[STS_OVF_BIT]             = r_ovf;
        STATUS_o[STS_BUSY_BIT]            = w_busy;
        STATUS_o[STS_GATE_BIT]            = r_gate;
        STATUS_o[STS_LVL_MSB:STS_LVL_LSB] = w_lvl4;
    end

endmodule

// File: tb/tb_vram_wr_seq.sv
// Directed self-checking bench for vram_wr_seq: a vector table for ungated command
// effects plus hand-written sequences for gating, overflow, flush and reset mid-fill.
module tb_vram_wr_seq;

    localparam logic [1:0] OP_SETADR = 2'b00;
    localparam logic [1:0] OP_DATA   = 2'b01;
    localparam logic [1:0] OP_FILL   = 2'b10;
    localparam logic [1:0] OP_CTRL   = 2'b11;

    typedef struct {
        logic [1:0] op;
        logic [9:0] pay;
        int         nWr;
        logic [9:0] lastAddr;
        logic [7:0] lastData;
    } vec_t;

    logic        clk;
    logic        rstN;
    logic [15:0] cmd;
    logic        xvd;
    logic [9:0]  wa;
    logic [7:0]  wd;
    logic        we;
    logic [15:0] status;

    logic        tg;
    int          total;
    int          bad;
    logic [17:0] wLog[$];
    vec_t        vecs[11];

    vram_wr_seq #(
        .C_FIFO_DEPTH  (8),
        .C_VB_GATE_DEF (1'b1)
    ) dut (
        .NFSC_CK_i  (clk),
        .XSYS_R_i   (rstN),
        .CMD_i      (cmd),
        .XVD_i      (xvd),
        .VRAM_WAs_o (wa),
        .VRAM_WDs_o (wd),
        .VRAM_WE_o  (we),
        .STATUS_o   (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstN && we) wLog.push_back({wa, wd});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [9:0] pay);
        tg  = ~tg;
        cmd = {tg, op, 3'b000, pay};
        tick();
        checkOutput("ack_toggle", 32'(status[15]), 32'(tg));
    endtask

    initial begin
        int base;
        int n0;
        logic [9:0] ea;

        total = 0;
        bad   = 0;
        tg    = 1'b0;
        cmd   = 16'h0000;
        xvd   = 1'b1;
        rstN  = 1'b0;

        vecs[0]  = '{OP_SETADR, 10'h3FE, 0,  10'h000, 8'h00};
        vecs[1]  = '{OP_DATA,   10'h041, 1,  10'h3FE, 8'h41};
        vecs[2]  = '{OP_DATA,   10'h042, 1,  10'h3FF, 8'h42};
        vecs[3]  = '{OP_DATA,   10'h007, 1,  10'h000, 8'h07};
        vecs[4]  = '{OP_SETADR, 10'h100, 0,  10'h000, 8'h00};
        vecs[5]  = '{OP_DATA,   10'h020, 1,  10'h100, 8'h20};
        vecs[6]  = '{OP_FILL,   10'h009, 10, 10'h10A, 8'h20};
        vecs[7]  = '{OP_FILL,   10'h000, 1,  10'h10B, 8'h20};
        vecs[8]  = '{OP_SETADR, 10'h3FF, 0,  10'h000, 8'h00};
        vecs[9]  = '{OP_DATA,   10'h0A5, 1,  10'h3FF, 8'hA5};
        vecs[10] = '{OP_FILL,   10'h001, 2,  10'h001, 8'hA5};

        repeat (3) @(negedge clk);
        checkOutput("rst_we", 32'(we), 32'h0);
        checkOutput("rst_wa", 32'(wa), 32'h0);
        checkOutput("rst_wd", 32'(wd), 32'h0);
        checkOutput("rst_status", 32'(status), 32'h1000);
        rstN = 1'b1;
        tick();
        tick();
        checkOutput("idle_status", 32'(status), 32'h1000);

        // Gate off: load enable (bit 2) with value 0 (bit 1).
        applyStimulus(OP_CTRL, 10'h004);
        checkOutput("gate_off", 32'(status[12]), 32'h0);

        for (int v = 0; v < 11; v++) begin
            base = wLog.size();
            applyStimulus(vecs[v].op, vecs[v].pay);
            repeat (8 + vecs[v].nWr) tick();
            checkOutput($sformatf("vec%0d_nwr", v), 32'(wLog.size() - base), 32'(vecs[v].nWr));
            for (int i = 0; i < vecs[v].nWr && (base + i) < wLog.size(); i++) begin
                ea = vecs[v].lastAddr - 10'(vecs[v].nWr - 1 - i);
                checkOutput($sformatf("vec%0d_wr%0d_addr", v, i), 32'(wLog[base+i][17:8]), 32'(ea));
                checkOutput($sformatf("vec%0d_wr%0d_data", v, i), 32'(wLog[base+i][7:0]), 32'(vecs[v].lastData));
            end
            if (vecs[v].nWr > 0) begin
                checkOutput($sformatf("vec%0d_hold_wa", v), 32'(wa), 32'(vecs[v].lastAddr));
                checkOutput($sformatf("vec%0d_hold_wd", v), 32'(wd), 32'(vecs[v].lastData));
            end
            checkOutput($sformatf("vec%0d_busy", v), 32'(status[13]), 32'h0);
            checkOutput($sformatf("vec%0d_we", v), 32'(we), 32'h0);
        end

        // Gated DATA waits for vertical blank, then strobes once at addr 0x002.
        applyStimulus(OP_CTRL, 10'h006);
        checkOutput("gate_on", 32'(status[12]), 32'h1);
        xvd  = 1'b1;
        base = wLog.size();
        applyStimulus(OP_DATA, 10'h055);
        repeat (10) tick();
        checkOutput("gated_nostrobe", 32'(wLog.size() - base), 32'h0);
        checkOutput("gated_busy", 32'(status[13]), 32'h1);
        xvd = 1'b0;
        n0  = 0;
        for (int i = 0; i < 2 && n0 == 0; i++) begin
            tick();
            if (we) n0 = 1;
        end
        checkOutput("vb_strobe_within2", 32'(n0), 32'h1);
        repeat (6) tick();
        checkOutput("vb_strobe_count", 32'(wLog.size() - base), 32'h1);
        if (wLog.size() > base) begin
            checkOutput("vb_addr", 32'(wLog[base][17:8]), 32'h002);
            checkOutput("vb_data", 32'(wLog[base][7:0]), 32'h55);
        end

        // Fill paused by XVD_i mid-way must still complete all writes.
        base = wLog.size();
        applyStimulus(OP_SETADR, 10'h100);
        applyStimulus(OP_DATA, 10'h020);
        applyStimulus(OP_FILL, 10'h009);
        for (int i = 0; i < 40 && (wLog.size() - base) < 5; i++) tick();
        checkOutput("fill_started", 32'((wLog.size() - base) >= 5), 32'h1);
        xvd = 1'b1;
        repeat (2) tick();
        n0 = wLog.size();
        repeat (5) tick();
        checkOutput("fill_paused", 32'(wLog.size() - n0), 32'h0);
        checkOutput("fill_paused_busy", 32'(status[13]), 32'h1);
        xvd = 1'b0;
        repeat (25) tick();
        checkOutput("fill_total", 32'(wLog.size() - base), 32'd11);
        for (int i = 0; i < 11 && (base + i) < wLog.size(); i++) begin
            checkOutput($sformatf("pfill%0d_addr", i), 32'(wLog[base+i][17:8]), 32'h100 + 32'(i));
            checkOutput($sformatf("pfill%0d_data", i), 32'(wLog[base+i][7:0]), 32'h20);
        end

        // Overflow: one DATA stalls in WAIT_VB, then nine more against an 8-deep FIFO.
        xvd  = 1'b1;
        base = wLog.size();
        applyStimulus(OP_DATA, 10'h011);
        repeat (6) tick();
        checkOutput("ovf_pre_level", 32'(status[3:0]), 32'h0);
        checkOutput("ovf_pre_busy", 32'(status[13]), 32'h1);
        for (int i = 0; i < 9; i++) applyStimulus(OP_DATA, 10'(10'h060 + i));
        repeat (3) tick();
        checkOutput("ovf_level", 32'(status[3:0]), 32'h8);
        checkOutput("ovf_sticky", 32'(status[14]), 32'h1);
        applyStimulus(OP_CTRL, 10'h001);
        checkOutput("flush_level", 32'(status[3:0]), 32'h0);
        checkOutput("flush_ovf", 32'(status[14]), 32'h0);
        checkOutput("flush_busy", 32'(status[13]), 32'h0);
        checkOutput("flush_gate_kept", 32'(status[12]), 32'h1);
        xvd = 1'b0;
        repeat (10) tick();
        checkOutput("flush_nostrobe", 32'(wLog.size() - base), 32'h0);

        // Reset in the middle of a 1024-write fill.
        applyStimulus(OP_CTRL, 10'h004);
        applyStimulus(OP_SETADR, 10'h000);
        applyStimulus(OP_DATA, 10'h033);
        applyStimulus(OP_FILL, 10'h3FF);
        repeat (20) tick();
        checkOutput("midfill_we", 32'(we), 32'h1);
        rstN = 1'b0;
        #1;
        checkOutput("rstfill_we", 32'(we), 32'h0);
        checkOutput("rstfill_wa", 32'(wa), 32'h0);
        checkOutput("rstfill_wd", 32'(wd), 32'h0);
        checkOutput("rstfill_status", 32'(status), 32'h1000);
        cmd = 16'h0000;
        tg  = 1'b0;
        repeat (2) tick();
        rstN = 1'b1;
        base = wLog.size();
        repeat (30) tick();
        checkOutput("postrst_nostrobe", 32'(wLog.size() - base), 32'h0);
        checkOutput("postrst_status", 32'(status), 32'h1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vram_wr_seq.md
VRAM_WR_SEQ -- requirements
Module: VRAM_WR_SEQ

Interface
REQ-001 SHALL have parameter C_FIFO_DEPTH, default 8, command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter C_VB_GATE_DEF, default 1'b1, reset value of the internal vertical-blank gate enable.
REQ-003 SHALL have port NFSC_CK_i  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port XSYS_R_i  in  1  asynchronous active-low reset.
REQ-005 SHALL have port CMD_i  in  16  CPU PIO command word: [15] toggle, [14:13] opcode, [12:10] ignored, [9:0] payload.
REQ-006 SHALL have port XVD_i  in  1  active-low vertical drive from the character generator; 0 = vertical blank.
REQ-007 SHALL have port VRAM_WAs_o  out  10  VRAM write address.
REQ-008 SHALL have port VRAM_WDs_o  out  8  VRAM write data.
REQ-009 SHALL have port VRAM_WE_o  out  1  one-cycle write strobe per VRAM write.
REQ-010 SHALL have port STATUS_o  out  16  [15] ack toggle, [14] overflow sticky, [13] busy, [12] VB gate enable, [11:4] 0, [3:0] FIFO level.

Function
REQ-011 SHALL register CMD_i[15] each cycle; a new command is a cycle where CMD_i[15] differs from the registered copy.
REQ-012 Opcodes: 00 SETADR (addr<=payload), 01 DATA (write payload[7:0] at addr, addr+1), 10 FILL (write last DATA byte to payload+1 consecutive addresses from addr), 11 CTRL.
REQ-013 SHALL push opcodes 00/01/10 with payload into the FIFO on the cycle after detection.
REQ-014 SHALL execute CTRL immediately, bypassing the FIFO: payload[0]=1 flushes FIFO, aborts any FILL/DATA in progress, clears overflow; payload[1] loads the VB gate enable; payload[2] sets gate enable to payload[1] only when payload[2]=1.
REQ-015 Push while FIFO full and no pop in the same cycle SHALL drop the command and set overflow; push and pop in the same cycle SHALL both succeed at any level.
REQ-016 STATUS_o[15] SHALL take the toggle value of every detected command (accepted, dropped, or CTRL) one cycle after detection.
REQ-017 State machine: IDLE, POP, WRITE, FILL, WAIT_VB; IDLE->POP when FIFO not empty; POP->IDLE for SETADR; POP->WRITE for DATA; POP->FILL for FILL.
REQ-018 WRITE and every FILL cycle SHALL proceed only when gate disabled or XVD_i=0; otherwise go/stay in WAIT_VB and resume into the interrupted state when permitted.
REQ-019 A DATA write SHALL assert VRAM_WE_o for exactly one cycle, two cycles after the pop cycle when ungated, with VRAM_WAs_o/VRAM_WDs_o valid in that same cycle.
REQ-020 FILL SHALL issue one write per cycle, payload+1 writes total (1..1024), pausing without loss while gated.
REQ-021 Address SHALL increment after every write and wrap 1023->0; FILL of 1024 leaves addr unchanged.
REQ-022 SETADR SHALL take effect for the next popped command; it produces no strobe.
REQ-023 Busy SHALL be 1 whenever state is not IDLE or FIFO is not empty.
REQ-024 VRAM_WAs_o/VRAM_WDs_o SHALL hold their last values when VRAM_WE_o=0.

Reset
REQ-025 On XSYS_R_i=0: state IDLE, FIFO empty, addr 0, last data 0, overflow 0, toggle copy and ack 0, VB gate = C_VB_GATE_DEF, all outputs 0 except STATUS_o[12].
REQ-026 Reset asserted mid-FILL SHALL terminate it with no further VRAM_WE_o after reset release.

Structure
REQ-027 Opcode constants, STATUS_o bit positions and state encodings SHALL live in the shared CHR_GEN constants package/include.
REQ-028 The FIFO SHALL be a separate sub-module VRAM_CMD_FIFO (sync FIFO, level output, same clock/reset).

Verification
REQ-029 SETADR 0x3FE, DATA 0x41, DATA 0x42, gate off -> writes (0x3FE,0x41),(0x3FF,0x42); addr ends 0x000.
REQ-030 Gate on, XVD_i=1, DATA 0x55 -> no strobe, busy=1; drop XVD_i to 0 -> single strobe within 2 cycles.
REQ-031 DATA 0x20 then FILL payload 9 at addr 0x100 -> 10 consecutive strobes, addresses 0x101..0x10A, data 0x20; XVD_i high mid-fill pauses, total still 10.
REQ-032 Gate on, XVD_i=1, push 9 commands with depth 8 -> level 8, STATUS_o[14]=1; CTRL payload 0x1 -> level 0, overflow 0, busy 0.
REQ-033 Reset during FILL of 1024 -> all outputs 0 next cycle, no strobes after release, level 0.
REQ-034 Toggle each command; STATUS_o[15] tracks CMD_i[15] with one-cycle lag including dropped commands.
